fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have these parameters:
- RESET_PC, default 32'h00000000, PC value after reset.
- NOP_INSTR, default 32'h00000013, bubble instruction (addi x0,x0,0).

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- stallF  in  1  hold PC.
- stallD  in  1  hold IF/ID register.
- flushD  in  1  load bubble into IF/ID.
- PCSrc_EX  in  1  taken branch/jump redirect from EX.
- PCTarget_EX  in  32  redirect target.
- imem_addr  out  32  synchronous instruction-memory read address; data returns next cycle.
- imem_rdata  in  32  instruction for imem_addr of previous cycle.
- instr_ID  out  32  decode-stage instruction.
- PC_ID  out  32  PC of instr_ID.
- PCplus4_ID  out  32  PC_ID+4.
- valid_ID  out  1  instr_ID is a real fetched instruction.
- misalign_err  out  1  sticky misaligned-target flag.
- fetch_count  out  32  valid instructions delivered to ID.
- redirect_count  out  16  redirects taken.

Function
REQ-003 The block SHALL hold an internal PC register PC_F and a two-state FSM: BOOT and RUN.
REQ-004 The FSM SHALL enter BOOT on reset and move to RUN unconditionally on the first clock edge after reset deasserts.
REQ-005 In BOOT, the block SHALL:
- drive imem_addr = PC_F;
- leave PC_F unchanged;
- load IF/ID with a bubble, because imem_rdata is not yet valid.
REQ-006 In RUN, the block SHALL drive imem_addr = pc_next combinationally and load PC_F <= pc_next each edge.
REQ-007 pc_next priority SHALL be:
- PCSrc_EX=1: {PCTarget_EX[31:2],2'b00};
- else stallF=1: PC_F;
- else: PC_F+4, 32-bit modulo; FFFFFFFC wraps to 00000000.
REQ-008 A redirect SHALL override stallF in the same cycle.
REQ-009 When PCSrc_EX=1 and PCTarget_EX[1:0]!=0, misalign_err SHALL set to 1 on that edge and stay 1 until reset.
REQ-010 IF/ID update priority SHALL be:
- flushD=1 or PCSrc_EX=1: bubble;
- else stallD=1: hold;
- else: load imem_rdata, PC_F, PC_F+4, valid_ID=1.
REQ-011 Flush SHALL take priority over stallD.
REQ-012 A bubble SHALL be instr_ID=NOP_INSTR, valid_ID=0, with PC_ID and PCplus4_ID unchanged.
REQ-013 Latency SHALL be as follows:
- An instruction at address A presented on imem_addr at edge N SHALL appear on instr_ID after edge N+1, absent stalls/flushes.
- A redirect at cycle N SHALL yield target instruction on instr_ID after edge N+2, with exactly one bubble between.
REQ-014 While stallF=1 and stallD=1, imem_addr SHALL equal PC_F, so imem_rdata stays consistent with PC_F; instr_ID/PC_ID SHALL be unchanged.
REQ-015 fetch_count SHALL increment by 1 on each edge where IF/ID loads with valid_ID=1, wrapping FFFFFFFF->0.
REQ-016 redirect_count SHALL increment on each edge with PCSrc_EX=1 in RUN, saturating at 16'hFFFF.
REQ-017 All outputs except imem_addr SHALL be registered.

Reset
REQ-018 Asserting reset (reset=0) SHALL immediately, without a clock edge, set:
- PC_F=RESET_PC, FSM=BOOT;
- instr_ID=NOP_INSTR, PC_ID=0, PCplus4_ID=0, valid_ID=0;
- misalign_err=0, fetch_count=0, redirect_count=0.
REQ-019 While reset=0, imem_addr SHALL equal RESET_PC.
REQ-020 Reset asserted mid-redirect or mid-stall SHALL discard all pending state; no redirect/count SHALL be retained.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Boot: reset low 3 cycles, release, imem returns A+0x100 as data for address A -> cycle1 after release valid_ID=0; then instr_ID=0x100,PC_ID=0; 0x104,PC_ID=4; fetch_count=2 after those.
- Stall: stallF=stallD=1 for 3 cycles at PC_F=0x10 -> imem_addr=0x10 held, instr_ID/PC_ID frozen, fetch_count frozen; resumes with PC_ID=0x0C then 0x10 with no loss/duplication.
- Redirect: PCSrc_EX=1,PCTarget_EX=0x80 with stallF=stallD=1 -> imem_addr=0x80 that cycle, next instr_ID=NOP_INSTR valid_ID=0, following PC_ID=0x80, redirect_count=1.
- Misaligned: PCTarget_EX=0x42 -> PC_F=0x40, misalign_err=1 and remains 1 after 10 further cycles; cleared only by reset.
- Flush priority: flushD=1 with stallD=1 -> instr_ID=NOP_INSTR, valid_ID=0, PC_ID unchanged.
- Wrap/saturate: PC_F=FFFFFFFC unstalled -> pc_next=0; force 65536 redirects -> redirect_count stays FFFF.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC register, boot FSM, IF/ID register and fetch statistics
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        PCSrc_EX,
  input  logic [31:0] PCTarget_EX,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_ID,
  output logic [31:0] PC_ID,
  output logic [31:0] PCplus4_ID,
  output logic        valid_ID,
  output logic        misalign_err,
  output logic [31:0] fetch_count,
  output logic [15:0] redirect_count
);
  typedef enum logic {BOOT, RUN} state_t;
  state_t state, state_nx;
  logic [31:0] pc_f, pc_next, pc_plus4;
  logic run, bubble, load;
  always_comb begin
    state_nx = RUN;
    run = state == RUN;
    pc_plus4 = pc_f + 32'd4;
    pc_next = PCSrc_EX ? {PCTarget_EX[31:2], 2'b00} : stallF ? pc_f : pc_plus4;
    imem_addr = run ? pc_next : pc_f;
    bubble = !run || flushD || PCSrc_EX;
    load = !bubble && !stallD;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_f <= RESET_PC;
    else if (run) pc_f <= pc_next;
  end
  // bubbles keep PC_ID/PCplus4_ID so downstream still sees the last real PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_ID   <= NOP_INSTR;
      PC_ID      <= 32'd0;
      PCplus4_ID <= 32'd0;
      valid_ID   <= 1'b0;
    end else if (bubble) begin
      instr_ID <= NOP_INSTR;
      valid_ID <= 1'b0;
    end else if (load) begin
      instr_ID   <= imem_rdata;
      PC_ID      <= pc_f;
      PCplus4_ID <= pc_plus4;
      valid_ID   <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_err   <= 1'b0;
      fetch_count    <= 32'd0;
      redirect_count <= 16'd0;
    end else begin
      misalign_err   <= misalign_err | (run & PCSrc_EX & |PCTarget_EX[1:0]);
      fetch_count    <= fetch_count + {31'd0, load};
      redirect_count <= (run && PCSrc_EX && redirect_count != 16'hFFFF) ? redirect_count + 16'd1 : redirect_count;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed stimulus against a transaction-level fetch model with a queued scoreboard
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, reset = 0, stallF = 0, stallD = 0, flushD = 0, PCSrc_EX = 0;
  logic [31:0] PCTarget_EX = 0, imem_rdata = 0;
  logic [31:0] imem_addr, instr_ID, PC_ID, PCplus4_ID, fetch_count;
  logic valid_ID, misalign_err;
  logic [15:0] redirect_count;
  int checks = 0, errors = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .PCSrc_EX(PCSrc_EX), .PCTarget_EX(PCTarget_EX), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_ID(instr_ID), .PC_ID(PC_ID), .PCplus4_ID(PCplus4_ID),
    .valid_ID(valid_ID), .misalign_err(misalign_err), .fetch_count(fetch_count),
    .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;
  // memory returns address+0x100 one cycle after the request
  always @(posedge clk) imem_rdata <= imem_addr + 32'h100;

  typedef struct {
    logic [31:0] addr, instr, pc, pc4, fc;
    logic valid, mis;
    logic [15:0] rc;
  } exp_t;
  exp_t q[$];

  bit booted = 0, m_valid = 0, m_mis = 0;
  logic [31:0] m_pc = 0, m_instr = NOP, m_pcid = 0, m_pc4 = 0, m_fc = 0;
  int m_rc = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, act, req);
    end
  endtask

  task automatic step(input bit rn, input bit sf, input bit sd, input bit fl, input bit br, input logic [31:0] tgt);
    exp_t e;
    logic [31:0] nxt;
    @(negedge clk);
    reset = rn; stallF = sf; stallD = sd; flushD = fl; PCSrc_EX = br; PCTarget_EX = tgt;
    if (!rn) begin
      booted = 0; m_pc = 0; m_instr = NOP; m_pcid = 0; m_pc4 = 0;
      m_valid = 0; m_mis = 0; m_fc = 0; m_rc = 0;
    end
    nxt = !booted ? m_pc : br ? (tgt & ~32'd3) : sf ? m_pc : m_pc + 32'd4;
    e.addr = nxt; e.instr = m_instr; e.pc = m_pcid; e.pc4 = m_pc4; e.fc = m_fc;
    e.valid = m_valid; e.mis = m_mis; e.rc = 16'(m_rc);
    q.push_back(e);
    if (!rn) return;
    if (!booted) begin
      booted = 1;
      m_instr = NOP;
      m_valid = 0;
    end else begin
      if (fl || br) begin
        m_instr = NOP;
        m_valid = 0;
      end else if (!sd) begin
        m_instr = m_pc + 32'h100;
        m_pcid = m_pc;
        m_pc4 = m_pc + 32'd4;
        m_valid = 1;
        m_fc = m_fc + 1;
      end
      if (br) begin
        m_mis = m_mis | (tgt[1:0] != 2'b00);
        if (m_rc < 65535) m_rc++;
      end
      m_pc = nxt;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr", imem_addr, e.addr);
        chk("instr_ID", instr_ID, e.instr);
        chk("PC_ID", PC_ID, e.pc);
        chk("PCplus4_ID", PCplus4_ID, e.pc4);
        chk("valid_ID", {31'd0, valid_ID}, {31'd0, e.valid});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
        chk("fetch_count", fetch_count, e.fc);
        chk("redirect_count", {16'd0, redirect_count}, {16'd0, e.rc});
      end
    end
  end

  initial begin
    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 32'h80);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h42);
    repeat (10) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'hFFFFFFFC);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    repeat (65540) step(1, 1'($urandom), 1'($urandom), 0, 1, {$urandom} & 32'h0000FFFC);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 32'h44);
    step(0, 1, 1, 0, 1, 32'h44);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      step($urandom_range(99) >= 2, $urandom_range(3) == 0, $urandom_range(3) == 0,
           $urandom_range(9) == 0, $urandom_range(9) == 0, t);
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
